// File: rtl/dot_matrix_pkg.sv
// Shared types, defaults and helpers for the dot-matrix scanner.
// The optional blanking window is enabled with the DOT_BLANK_EN macro.
package dot_matrix_pkg;

  localparam int unsigned DEF_NUM_COLS = 5;
  localparam int unsigned DEF_NUM_ROWS = 7;
  localparam int unsigned DEF_DWELL    = 1024;
  localparam int unsigned DEF_BLANK    = 8;
  localparam int unsigned MAX_COLS     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Per-cycle strobes describing where the scan currently is
  typedef struct packed {
    logic active;
    logic col_end;
    logic frame_end;
    logic blank;
    logic first;
  } scan_strobe_t;

  function automatic logic [MAX_COLS-1:0] onehot(input int unsigned idx);
    onehot = MAX_COLS'(1) << idx;
  endfunction

endpackage

// File: rtl/dot_scan_timer.sv
// Dwell counter and column index for the dot-matrix scan, with IDLE/SCAN control.
// Blanking strobe is only raised when DOT_BLANK_EN is defined.
module dot_scan_timer
  import dot_matrix_pkg::*;
#(
  parameter int unsigned NUM_COLS = DEF_NUM_COLS,
  parameter int unsigned DWELL    = DEF_DWELL,
  parameter int unsigned BLANK    = DEF_BLANK,
  localparam int unsigned COL_W   = $clog2(NUM_COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [COL_W-1:0] col,
  output scan_strobe_t     strobe_c
);

  localparam int unsigned      CNT_W      = $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_FROM = CNT_W'(DWELL - BLANK);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(NUM_COLS - 1);
`ifdef DOT_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  scan_state_t      state;
  scan_state_t      state_next;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = SCAN;
      SCAN:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    strobe_c        = '0;
    strobe_c.active = (state == SCAN);
    if (state == SCAN) begin
      strobe_c.col_end   = (cnt == CNT_LAST);
      strobe_c.frame_end = (cnt == CNT_LAST) && (col == COL_LAST);
      strobe_c.blank     = BLANK_ON && (cnt >= BLANK_FROM);
      strobe_c.first     = (cnt == '0) && (col == '0);
    end
  end

  // Position only advances while scanning and still enabled; anything else discards it
  always_ff @(posedge clk) begin
    if (reset || !((state == SCAN) && enable)) begin
      cnt <= '0;
      col <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dot_matrix_scanner.sv
// Double-buffered LED dot-matrix driver: back-buffer writes, tear-free swaps, column scan.
// Define DOT_BLANK_EN to blank the last BLANK cycles of every column dwell.
module dot_matrix_scanner
  import dot_matrix_pkg::*;
#(
  parameter int unsigned NUM_COLS = DEF_NUM_COLS,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter int unsigned DWELL    = DEF_DWELL,
  parameter int unsigned BLANK    = DEF_BLANK,
  localparam int unsigned COL_W   = $clog2(NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                write,
  input  logic [COL_W-1:0]    colAddr,
  input  logic [NUM_ROWS-1:0] rowIn,
  input  logic                swap,
  output logic                swapPending,
  output logic                frameStart,
  output logic [NUM_COLS-1:0] colOut,
  output logic [NUM_ROWS-1:0] rowOut
);

  logic [NUM_ROWS-1:0] bank [2][NUM_COLS];
  logic                front;
  logic [COL_W-1:0]    col;
  scan_strobe_t        strobe_c;
  logic                addr_ok_c;
  logic                apply_c;
  logic                drive_c;

  dot_scan_timer #(
    .NUM_COLS (NUM_COLS),
    .DWELL    (DWELL),
    .BLANK    (BLANK)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .col      (col),
    .strobe_c (strobe_c)
  );

  assign addr_ok_c = 32'(colAddr) < NUM_COLS;
  assign apply_c   = swapPending && (!enable || strobe_c.frame_end);
  assign drive_c   = strobe_c.active && enable && !strobe_c.blank;

  // Writes always target the bank not currently displayed, using pre-swap front
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
          bank[b][c] <= '0;
        end
      end
    end else if (write && addr_ok_c) begin
      bank[~front][colAddr] <= rowIn;
    end
  end

  // Swap is a pointer flip; requests arriving while one is pending are absorbed
  always_ff @(posedge clk) begin
    if (reset) begin
      front       <= 1'b0;
      swapPending <= 1'b0;
    end else if (apply_c) begin
      front       <= ~front;
      swapPending <= 1'b0;
    end else if (swap) begin
      swapPending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      colOut     <= '0;
      rowOut     <= '0;
      frameStart <= 1'b0;
    end else begin
      colOut     <= drive_c ? NUM_COLS'(onehot(32'(col))) : '0;
      rowOut     <= drive_c ? bank[front][col] : '0;
      frameStart <= strobe_c.active && enable && strobe_c.first;
    end
  end

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Scoreboard bench for dot_matrix_scanner; reference model tracks scan time arithmetically.
// Honors DOT_BLANK_EN when the design is built with it.
module tb_dot_matrix_scanner;

  localparam int unsigned NC = 5;
  localparam int unsigned NR = 7;
  localparam int unsigned DW = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned FRAME = NC * DW;

  logic          clk = 1'b0;
  logic          reset, enable, write, swap;
  logic [2:0]    colAddr;
  logic [NR-1:0] rowIn;
  logic          swapPending, frameStart;
  logic [NC-1:0] colOut;
  logic [NR-1:0] rowOut;

  typedef struct {
    logic [NC-1:0] col;
    logic [NR-1:0] row;
    logic          fs;
    logic          sp;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference state: consecutive enabled edges, displayed bank, pending flag, both banks
  int            run;
  bit            front_m;
  bit            pend_m;
  logic [NR-1:0] mem_m [2][NC];

  dot_matrix_scanner #(
    .NUM_COLS (NC),
    .NUM_ROWS (NR),
    .DWELL    (DW),
    .BLANK    (BL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .write       (write),
    .colAddr     (colAddr),
    .rowIn       (rowIn),
    .swap        (swap),
    .swapPending (swapPending),
    .frameStart  (frameStart),
    .colOut      (colOut),
    .rowOut      (rowOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    exp_t e;
    int   t, col_i, cnt_i;
    bit   scanning, drive, blank, frame_end;
    if (reset) begin
      run = 0; front_m = 0; pend_m = 0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < int'(NC); c++) mem_m[b][c] = '0;
      e.col = '0; e.row = '0; e.fs = 1'b0; e.sp = 1'b0;
    end else begin
      scanning = (run >= 1);
      t = run - 1;
      col_i = 0; cnt_i = 0;
      if (scanning) begin
        col_i = (t / int'(DW)) % int'(NC);
        cnt_i = t % int'(DW);
      end
      drive = scanning && enable;
`ifdef DOT_BLANK_EN
      blank = (cnt_i >= int'(DW - BL));
`else
      blank = 1'b0;
`endif
      e.col = (drive && !blank) ? NC'(1 << col_i) : '0;
      e.row = (drive && !blank) ? mem_m[front_m][col_i] : '0;
      e.fs  = drive && (t % int'(FRAME) == 0);
      frame_end = scanning && (t % int'(FRAME) == int'(FRAME) - 1);
      if (write && colAddr < 3'(NC)) mem_m[!front_m][colAddr] = rowIn;
      if (pend_m && (!enable || frame_end)) begin
        front_m = !front_m;
        pend_m  = 1'b0;
      end else if (swap) begin
        pend_m = 1'b1;
      end
      e.sp = pend_m;
      run = enable ? run + 1 : 0;
    end
    sb.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("colOut",      32'(colOut),      32'(e.col));
      chk("rowOut",      32'(rowOut),      32'(e.row));
      chk("frameStart",  32'(frameStart),  32'(e.fs));
      chk("swapPending", 32'(swapPending), 32'(e.sp));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait until the next edge lands at scan position (run % FRAME == phase)
  task automatic wait_phase(input int phase, input string name);
    int k;
    k = 0;
    while (!((run > 0) && (run % int'(FRAME) == phase)) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL wait_%s: got timeout, required scan phase %0d", name, phase);
    end
  endtask

  initial begin
    logic [NR-1:0] vals [NC];
    vals[0] = 7'h01; vals[1] = 7'h03; vals[2] = 7'h07; vals[3] = 7'h1F; vals[4] = 7'h7F;
    reset = 1'b1; enable = 1'b0; write = 1'b0; swap = 1'b0; colAddr = '0; rowIn = '0;
    cycles(3);
    reset = 1'b0; enable = 1'b1;
    cycles(2 * FRAME + 3);

    // Fill back buffer, then swap mid-frame
    for (int i = 0; i < int'(NC); i++) begin
      write = 1'b1; colAddr = 3'(i); rowIn = vals[i];
      cycles(1);
    end
    write = 1'b0;
    wait_phase(7, "midframe");
    swap = 1'b1; cycles(1); swap = 1'b0;
    cycles(2 * FRAME + 2);

    // Out-of-range addresses must not land anywhere
    write = 1'b1; colAddr = 3'd5; rowIn = 7'h7F; cycles(1);
    colAddr = 3'd7; rowIn = 7'h55; cycles(1);
    write = 1'b0;
    swap = 1'b1; cycles(1); swap = 1'b0;
    cycles(2 * FRAME + 2);

    // Drop enable during column 2, then restart
    wait_phase(10, "col2");
    enable = 1'b0; cycles(3);
    enable = 1'b1; cycles(FRAME + 5);

    // Swap while idle
    enable = 1'b0; cycles(1);
    swap = 1'b1; cycles(1); swap = 1'b0;
    cycles(3);
    enable = 1'b1; cycles(FRAME + 2);

    // Write coinciding with the swap-application edge
    swap = 1'b1; cycles(1); swap = 1'b0;
    wait_phase(0, "frame_end");
    write = 1'b1; colAddr = 3'd3; rowIn = 7'h55; cycles(1);
    write = 1'b0;
    cycles(2 * FRAME + 2);

    // Randomized traffic
    repeat (1500) begin
      enable  = ($urandom_range(0, 15) != 0);
      write   = ($urandom_range(0, 2) == 0);
      colAddr = 3'($urandom_range(0, 7));
      rowIn   = 7'($urandom);
      swap    = ($urandom_range(0, 19) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    reset = 1'b0; write = 1'b0; swap = 1'b0; enable = 1'b1;
    cycles(FRAME + 2);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scanner.md
# dot_matrix_scanner

Parametrised, double-buffered LED dot-matrix driver for the display path. Software/upstream logic writes one column of row bits per cycle into a back buffer. The block continuously scans the front buffer onto one-hot column drives and row drives, with a fixed dwell time per column. A swap request exchanges the two buffers at the next frame boundary, so a frame never tears.

## Interface
- `NUM_COLS`, default 5: number of columns; must be 2..32.
- `NUM_ROWS`, default 7: row bits per column; must be 1..32.
- `DWELL`, default 1024: clock cycles each column is driven; must be at least 2.
- `BLANK`, default 8: dead cycles at the end of each dwell; must satisfy 1 ≤ BLANK < DWELL; used only with `DOT_BLANK_EN`.
- `COL_W`, derived: $clog2(NUM_COLS).

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: scan enable.
- `write` in 1: write strobe for the back buffer.
- `colAddr` in COL_W: column to write.
- `rowIn` in NUM_ROWS: row bits for `colAddr`.
- `swap` in 1: request a buffer exchange; level-sampled and treated as a pulse.
- `swapPending` out 1: swap requested but not yet applied.
- `frameStart` out 1: one-cycle pulse on the first cycle column 0 is driven.
- `colOut` out NUM_COLS: one-hot active column, bit i is column i.
- `rowOut` out NUM_ROWS: front-buffer bits for the active column.

## Operation
- **Buffers:** two banks of NUM_COLS × NUM_ROWS bits. A bank-select bit `front` chooses which bank is displayed; the other bank is the back buffer.
- **Writes:**
  - `write`=1 with `colAddr` < NUM_COLS: `back[colAddr]` ← `rowIn`.
  - `colAddr` ≥ NUM_COLS: the write is ignored and nothing changes.
  - Writes are accepted whether or not `enable` is high.
- **Swap request:** `swap`=1 sets `swapPending`. Further swaps while pending are absorbed; swaps never queue.
- **Swap application:**
  - With `enable`=1: the swap applies on the last cycle of column NUM_COLS-1's dwell. `front` toggles and `swapPending` clears on the same edge, so the next frame shows the new bank.
  - With `enable`=0: a pending swap applies on the next edge.
- **No copy on swap:** the banks exchange by pointer only. After a swap the back buffer holds the previous front contents.
- **Scan FSM:**
  - **IDLE** (`enable`=0): `colOut`=0, `rowOut`=0, and the column index and dwell counter are held at 0.
  - **SCAN** (`enable`=1): the dwell counter counts 0..DWELL-1. At DWELL-1 the counter returns to 0 and the column index advances, wrapping from NUM_COLS-1 to 0.
  - `enable` falling in SCAN returns to IDLE on the next edge and the scan position is discarded.
- **Outputs in SCAN:** `colOut` = onehot(col) and `rowOut` = `front[col]`, except during blanking (see Configuration).
- **Simultaneous events:**
  - A write in the same cycle as the swap application lands in the old back bank, which becomes front. That data is therefore displayed in the new frame.
  - `swap` and `reset` together: reset wins.
- **Reset:** clears both banks, `front`=0, `swapPending`=0, the column index and counter, `colOut`=0, `rowOut`=0 and `frameStart`=0. Reset mid-scan is immediate on the next edge.

## Timing
- All outputs are registered; none has a combinational path from inputs.
- `enable` sampled 1 at edge N (from IDLE): `colOut`=1 and `frameStart`=1 are valid after edge N+1.
- Each column is driven for exactly DWELL cycles, so a frame is NUM_COLS×DWELL cycles.
- `frameStart` pulses once per frame, aligned to the first cycle of column 0, including the first frame after enable.
- Write at edge W is visible on `rowOut` only after a swap has been applied, and only when that column is next scanned.
- `swapPending` rises the cycle after `swap` is sampled and falls on the same edge that toggles `front`.

## Configuration
- Macro: `DOT_BLANK_EN`.
- **Defined:** in the last BLANK cycles of each dwell (counter ≥ DWELL-BLANK), `colOut`=0 and `rowOut`=0 to suppress ghosting. Counter timing is unchanged.
- **Undefined:** no blanking; outputs are driven for the full DWELL, and `BLANK` is unused.

## Structure
- **Package `dot_matrix_pkg`:**
  - Default parameter constants for NUM_COLS, NUM_ROWS, DWELL and BLANK.
  - The scan-state enum {IDLE, SCAN}.
  - A `onehot` function.
- **Sub-module `dot_scan_timer`:**
  - Contains the dwell counter and column index, with wrap handling.
  - Outputs the column index, end-of-column, end-of-frame, blanking window and first-cycle strobes.
- **Top level:** holds the buffers, the swap logic and the output registers.

## Test plan
All scenarios use NUM_COLS=5, NUM_ROWS=7, DWELL=4, BLANK=1.
- **Reset values:** reset high for 3 cycles, then enable=1 → after reset, `colOut`=0 and `rowOut`=0. First scanned frame shows all columns with `rowOut`=0, and `frameStart` pulses every 20 cycles.
- **Write then swap:** write col0..4 = 7'h01, 03, 07, 1F, 7F, then pulse swap mid-frame. Required response:
  - `swapPending`=1 until the end of column 4.
  - Next frame shows `colOut`=5'b00001 with `rowOut`=7'h01 through 5'b10000 with 7'h7F, 4 cycles each.
- **Invalid address:** write with `colAddr`=5 or 7 → contents of both banks are unchanged (checked after a swap).
- **Enable drop mid-frame:** deassert enable during column 2 → outputs go to 0 on the next edge. Re-enable → scan restarts at column 0 with `frameStart`=1.
- **Swap while idle, and collision:**
  - enable=0 + swap → `front` toggles on the next edge.
  - Write in the same cycle as the swap application → the data appears in the following frame.
- **Blanking:** with `DOT_BLANK_EN`, cycle 3 of every column has `colOut`=0 and `rowOut`=0. Without it, all 4 dwell cycles are driven.
